// File: rtl/mem_s2_arbiter_if.sv
// Bundle of the two requester ports, the s2 memory port and the busy flag.
// master = arbiter side, slave = requesters plus memory side.
interface mem_s2_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [3:0]        a_be;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [3:0]        b_be;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;

  logic              busy;

  modport master (
    input  a_req, a_we, a_addr, a_wdata, a_be,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output b_ack, b_rdata, b_rvalid,
    output mem_address, mem_chipselect, mem_clken, mem_write,
    output mem_writedata, mem_byteenable,
    input  mem_readdata,
    output busy
  );

  modport slave (
    output a_req, a_we, a_addr, a_wdata, a_be,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  b_ack, b_rdata, b_rvalid,
    input  mem_address, mem_chipselect, mem_clken, mem_write,
    input  mem_writedata, mem_byteenable,
    output mem_readdata,
    input  busy
  );
endinterface

// File: rtl/mem_s2_arbiter.sv
// Round-robin arbiter sharing the s2 port of the dual-port on-chip memory
// between the SPI bridge (A) and fabric logic (B); one access in flight.
//   state   | meaning
//   IDLE    | sample requests, grant and latch command
//   ISSUE   | command on s2, ack to granted requester
//   WAIT_RD | wait READ_LATENCY cycles, then return read data
module mem_s2_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  mem_s2_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;   // 1 = B was granted last
  logic              gnt_q, gnt_d;     // 1 = B is being served
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              busy_q, busy_d;
  logic              clken_q;

  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;

  assign pick_b    = bus.b_req & (~bus.a_req | ~last_q);
  assign sel_we    = pick_b ? bus.b_we    : bus.a_we;
  assign sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
  assign sel_be    = pick_b ? bus.b_be    : bus.a_be;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      busy_q     <= 1'b0;
      clken_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      busy_q     <= busy_d;
      clken_q    <= 1'b1;
    end
  end

  // s2 command outputs are computed one cycle early so they are registered
  // when ISSUE begins; the registers double as the latched command.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    addr_d     = '0;
    cs_d       = 1'b0;
    write_d    = 1'b0;
    wdata_d    = '0;
    be_d       = '0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d = ISSUE;
          gnt_d   = pick_b;
          last_d  = pick_b;
          cs_d    = 1'b1;
          addr_d  = sel_addr;
          write_d = sel_we;
          wdata_d = sel_we ? sel_wdata : '0;
          be_d    = sel_we ? sel_be : 4'hF;
          a_ack_d = ~pick_b;
          b_ack_d = pick_b;
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = 2'(READ_LATENCY);
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
          if (gnt_q) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = bus.mem_readdata;
          end else begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = bus.mem_readdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_clken      = clken_q;
  assign bus.mem_write      = write_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
  assign bus.a_ack          = a_ack_q;
  assign bus.b_ack          = b_ack_q;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.a_rdata        = a_rdata_q;
  assign bus.b_rdata        = b_rdata_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_mem_s2_arbiter.sv
// Directed bench for mem_s2_arbiter: main instance with READ_LATENCY=1 on a
// byte-enabled memory model, second instance with READ_LATENCY=3 for reset abort.
module tb_mem_s2_arbiter;
  logic clk_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic rst3_n  = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk_clk = ~clk_clk;

  mem_s2_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();
  mem_s2_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus3 ();

  mem_s2_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LATENCY(1)) u_dut (
    .clk_clk(clk_clk), .reset_reset_n(rst_n), .bus(bus.master));

  mem_s2_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LATENCY(3)) u_dut3 (
    .clk_clk(clk_clk), .reset_reset_n(rst3_n), .bus(bus3.master));

  logic [31:0] mem [0:127];
  logic [31:0] rd_q = '0;

  always @(posedge clk_clk) begin
    if (bus.mem_chipselect && bus.mem_write) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_byteenable[k]) mem[bus.mem_address][8*k +: 8] <= bus.mem_writedata[8*k +: 8];
    end
    if (bus.mem_chipselect && !bus.mem_write) rd_q <= mem[bus.mem_address];
  end
  assign bus.mem_readdata  = rd_q;
  assign bus3.mem_readdata = 32'hCAFEF00D;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0;
    tick(); tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.mem_clken !== 1'b1) begin bad++; $display("FAIL rst_clken got=%0h exp=1", bus.mem_clken); end
    total++; if (bus.mem_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs got=%0h exp=0", bus.mem_chipselect); end
    total++; if ({bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid} !== 4'b0) begin bad++; $display("FAIL rst_hs got=%b exp=0000", {bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid}); end
    total++; if (bus.mem_byteenable !== 4'h0) begin bad++; $display("FAIL rst_be got=%h exp=0", bus.mem_byteenable); end
    total++; if (bus.a_rdata !== 32'h0) begin bad++; $display("FAIL rst_a_rdata got=%h exp=0", bus.a_rdata); end
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 7'h05; bus.a_wdata = 32'hDEADBEEF; bus.a_be = 4'hF;
    tick();
    bus.a_req = 1'b0;
    total++; if (bus.a_ack !== 1'b1 || bus.b_ack !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=10", bus.a_ack, bus.b_ack); end
    total++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1) begin bad++; $display("FAIL wr_cs_we got=%b%b exp=11", bus.mem_chipselect, bus.mem_write); end
    total++; if (bus.mem_address !== 7'h05) begin bad++; $display("FAIL wr_addr got=%h exp=05", bus.mem_address); end
    total++; if (bus.mem_writedata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", bus.mem_writedata); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wr_busy1 got=%0h exp=1", bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.a_ack !== 1'b0 || bus.mem_chipselect !== 1'b0) begin bad++; $display("FAIL wr_done got=%b%b%b exp=000", bus.busy, bus.a_ack, bus.mem_chipselect); end
  endtask

  task automatic test_single_read();
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'h05; bus.b_wdata = 32'h12345678; bus.b_be = 4'h3;
    tick();
    bus.b_req = 1'b0;
    total++; if (bus.b_ack !== 1'b1 || bus.a_ack !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b%b exp=01", bus.a_ack, bus.b_ack); end
    total++; if (bus.mem_write !== 1'b0 || bus.mem_byteenable !== 4'hF || bus.mem_writedata !== 32'h0) begin bad++; $display("FAIL rd_cmd got=%b %h %h exp=0 f 0", bus.mem_write, bus.mem_byteenable, bus.mem_writedata); end
    tick();
    total++; if (bus.b_rvalid !== 1'b0 || bus.busy !== 1'b1 || bus.mem_chipselect !== 1'b0) begin bad++; $display("FAIL rd_wait got=%b%b%b exp=010", bus.b_rvalid, bus.busy, bus.mem_chipselect); end
    tick();
    total++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%b %h exp=1 deadbeef", bus.b_rvalid, bus.b_rdata); end
    total++; if (bus.a_rvalid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rd_other got=%b%b exp=00", bus.a_rvalid, bus.busy); end
    tick();
    total++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%b %h exp=0 deadbeef", bus.b_rvalid, bus.b_rdata); end
  endtask

  task automatic test_contention();
    int n_gr = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 7'h10; bus.a_wdata = 32'h11110000; bus.a_be = 4'hF;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 7'h11; bus.b_wdata = 32'h22220000; bus.b_be = 4'hF;
    for (int c = 0; c < 30 && n_gr < 6; c++) begin
      tick();
      total++; if (bus.a_ack && bus.b_ack) begin bad++; $display("FAIL cont_double_ack got=11 exp=not both"); end
      if (bus.a_ack || bus.b_ack) begin
        total++; if (bus.b_ack !== n_gr[0]) begin bad++; $display("FAIL cont_order grant=%0d got_b=%b exp_b=%b", n_gr, bus.b_ack, n_gr[0]); end
        total++; if (bus.mem_address !== (n_gr[0] ? 7'h11 : 7'h10)) begin bad++; $display("FAIL cont_addr grant=%0d got=%h", n_gr, bus.mem_address); end
        n_gr++;
        if (n_gr == 6) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
      end
    end
    total++; if (n_gr != 6) begin bad++; $display("FAIL cont_timeout got=%0d exp=6", n_gr); end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick(); tick();
    total++; if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL cont_quiet got=%b%b%b exp=000", bus.a_ack, bus.b_ack, bus.busy); end
  endtask

  task automatic test_byte_enable();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 7'h7F; bus.a_wdata = 32'h000000AA; bus.a_be = 4'h1;
    tick();
    bus.a_req = 1'b0;
    total++; if (bus.mem_byteenable !== 4'h1 || bus.mem_address !== 7'h7F) begin bad++; $display("FAIL be_wr got=%h %h exp=1 7f", bus.mem_byteenable, bus.mem_address); end
    tick();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_be = 4'h2;
    tick();
    bus.a_req = 1'b0;
    total++; if (bus.a_ack !== 1'b1 || bus.mem_byteenable !== 4'hF || bus.mem_write !== 1'b0) begin bad++; $display("FAIL be_rd got=%b %h %b exp=1 f 0", bus.a_ack, bus.mem_byteenable, bus.mem_write); end
    tick(); tick();
    total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'h000000AA) begin bad++; $display("FAIL be_rdata got=%b %h exp=1 000000aa", bus.a_rvalid, bus.a_rdata); end
    tick();
  endtask

  task automatic test_late_request();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'h10;
    tick();
    bus.a_req = 1'b0;
    total++; if (bus.a_ack !== 1'b1) begin bad++; $display("FAIL late_a_ack got=%b exp=1", bus.a_ack); end
    tick();
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'h11;
    tick();
    total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'h11110000 || bus.b_ack !== 1'b0) begin bad++; $display("FAIL late_a_rd got=%b %h %b exp=1 11110000 0", bus.a_rvalid, bus.a_rdata, bus.b_ack); end
    tick();
    bus.b_req = 1'b0;
    total++; if (bus.b_ack !== 1'b1 || bus.mem_address !== 7'h11) begin bad++; $display("FAIL late_b_ack got=%b %h exp=1 11", bus.b_ack, bus.mem_address); end
    tick(); tick();
    total++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h22220000) begin bad++; $display("FAIL late_b_rd got=%b %h exp=1 22220000", bus.b_rvalid, bus.b_rdata); end
    total++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'h11110000) begin bad++; $display("FAIL late_a_hold got=%b %h exp=0 11110000", bus.a_rvalid, bus.a_rdata); end
  endtask

  task automatic test_reset_mid_read();
    int pulses = 0;
    bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = 7'h33;
    tick();
    bus3.a_req = 1'b0;
    total++; if (bus3.a_ack !== 1'b1 || bus3.mem_chipselect !== 1'b1) begin bad++; $display("FAIL abort_issue got=%b%b exp=11", bus3.a_ack, bus3.mem_chipselect); end
    tick();
    total++; if (bus3.busy !== 1'b1) begin bad++; $display("FAIL abort_wait got=%b exp=1", bus3.busy); end
    rst3_n = 1'b0;
    tick();
    rst3_n = 1'b1;
    total++; if (bus3.busy !== 1'b0 || bus3.mem_chipselect !== 1'b0 || bus3.mem_write !== 1'b0 || bus3.mem_clken !== 1'b1) begin bad++; $display("FAIL abort_rst got=%b%b%b%b exp=0001", bus3.busy, bus3.mem_chipselect, bus3.mem_write, bus3.mem_clken); end
    total++; if (bus3.mem_address !== 7'h0 || bus3.mem_byteenable !== 4'h0 || bus3.a_rdata !== 32'h0) begin bad++; $display("FAIL abort_zero got=%h %h %h exp=0 0 0", bus3.mem_address, bus3.mem_byteenable, bus3.a_rdata); end
    for (int c = 0; c < 8; c++) begin
      if (bus3.a_rvalid || bus3.b_rvalid || bus3.a_ack || bus3.b_ack) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_rvalid got=%0d exp=0", pulses); end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_be = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_be = '0;
    bus3.a_req = 1'b0; bus3.a_we = 1'b0; bus3.a_addr = '0; bus3.a_wdata = '0; bus3.a_be = '0;
    bus3.b_req = 1'b0; bus3.b_we = 1'b0; bus3.b_addr = '0; bus3.b_wdata = '0; bus3.b_be = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_byte_enable();
    test_late_request();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
